unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Shares one single-port synchronous `RAM` instance between the CPU instruction-fetch port and the CPU data port. This lets a single 4096-word memory hold both program (words 0–2047) and data (words 2048–4095). The block sits between `CPU` and the `RAM`:

- It grants at most one access per cycle.
- Data accesses have priority, with a bounded-starvation guarantee for fetch.
- It steers the one-cycle-late read data back to whichever requester issued the read.

## Interface

Parameters:

- `ADDR_W`, 12, word-address width of the shared RAM.
- `DATA_W`, 32, data width.
- `MAX_STARVE`, 4, consecutive contested cycles data may win before fetch is forced through (range 1–15).

Ports:

- `clk` input 1 — single clock; all state updates on rising edge.
- `rst` input 1 — asynchronous, active-high reset.
- `if_req` input 1 — fetch read request.
- `if_addr` input ADDR_W — fetch address.
- `if_gnt` output 1 — fetch accepted this cycle.
- `if_rvalid` output 1 — `if_rdata` valid.
- `if_rdata` output DATA_W — fetch read data.
- `d_req` input 1 — data request.
- `d_we` input 1 — 1 = write, 0 = read.
- `d_addr` input ADDR_W — data address.
- `d_wdata` input DATA_W — write data.
- `d_gnt` output 1 — data access accepted this cycle.
- `d_rvalid` output 1 — `d_rdata` valid (reads only).
- `d_rdata` output DATA_W — data read data.
- `mem_w_en` output 1 — RAM write enable.
- `mem_addr` output ADDR_W — RAM address.
- `mem_w_data` output DATA_W — RAM write data.
- `mem_r_data` input DATA_W — RAM read data, valid the cycle after the address is presented.

## Operation

**Handshake**
- A requester holds `req`, address, `we` and `wdata` stable until it sees `gnt` high.
- An access completes in the cycle where `req && gnt` is true.
- `if_gnt` and `d_gnt` are combinational from the `req` inputs and the starvation counter. They are never high together.

**Arbitration**
- Only one requester active: it is granted.
- Both requesters active (contested cycle): data wins unless `starve_cnt == MAX_STARVE`, in which case fetch wins.

**Starvation counter** (`starve_cnt`, 4 bits)
- Increments on every contested cycle that data wins.
- Clears when fetch is granted.
- Clears when `if_req` is low.

**Memory drive**
- `mem_addr` = address of the granted requester.
- With no grant, `mem_addr` holds the last value driven, so `mem_r_data` is not disturbed.
- `mem_w_en = d_gnt && d_we`.
- `mem_w_data = d_wdata`.

**Read return**
- A registered owner tag, `rd_owner`, takes one of three values: NONE, IF or D. It is set in the grant cycle of a read, and to NONE otherwise.
- In the next cycle, `mem_r_data` is routed to the owner's `rdata` and its `rvalid` pulses for one cycle.
- `if_rdata` and `d_rdata` pass `mem_r_data` through combinationally. They are qualified only by `rvalid`.
- Writes produce no `rvalid`.

**Reset**
- `rst` asserted clears `starve_cnt` to 0 and `rd_owner` to NONE.
- While `rst` is high, `if_gnt`, `d_gnt` and `mem_w_en` are forced to 0.
- Reset values of the registered outputs: `if_rvalid = 0`, `d_rvalid = 0`, `mem_addr = 0`.

## Timing

- Grant latency is 0 cycles (same cycle as `req`) when uncontested.
- Read latency is 1 cycle from grant to `rvalid`.
- Throughput is one access per cycle. Back-to-back reads by different requesters return in grant order on consecutive cycles.
- Worst-case fetch wait under continuous data traffic is `MAX_STARVE` cycles. Fetch is granted on the cycle after `MAX_STARVE` data wins.
- Write takes effect at the rising edge ending the grant cycle.
- Reset mid-read: if `rst` is asserted in the cycle after a read grant, no `rvalid` is produced. The requester must re-issue the read.
- A requester may drop `req` before being granted. It receives no grant and no `rvalid`.

## Structure

- Shared package `mem_arb_pkg` holds:
  - the `rd_owner` encoding (NONE = 2'd0, IF = 2'd1, D = 2'd2);
  - the default widths;
  - the memory map constants: `IM_BASE` 0, `DM_BASE` 2048, `DM_OUT_BASE` 3072, `DONE_ADDR` 4095.
- One sub-module, `arb_starve_prio`, contains the combinational grant logic plus `starve_cnt`. The top level adds the memory mux and the read-return register.

## Test plan

1. **Fetch only:** `if_req` with addresses 0x000, 0x001, 0x002 on consecutive cycles, RAM preloaded with `mem[i] = i + 0x100`. Required:
   - `if_gnt` is high for 3 cycles;
   - `if_rvalid` is high on the next 3 cycles with `if_rdata` = 0x100, 0x101, 0x102;
   - `d_rvalid` stays at 0.
2. **Data write, fetch idle:** `d_req=1`, `d_we=1`, `d_addr=0xFFF`, `d_wdata=0xFFFFFFFF`. Required:
   - `d_gnt` and `mem_w_en` are 1 in the same cycle;
   - `mem[4095]` reads 0xFFFFFFFF afterwards;
   - no `rvalid` on either port.
3. **Both requesting continuously, `MAX_STARVE=4`:** required grant sequence D, D, D, D, IF repeating. `if_gnt` is high on every 5th cycle, and `starve_cnt` returns to 0 after each fetch grant.
4. **Interleaved reads:** D read of 0x800 granted in cycle N, IF read of 0x004 granted in N+1. Required:
   - `d_rvalid` in N+1 with `mem[0x800]`;
   - `if_rvalid` in N+2 with `mem[0x004]`;
   - no cross-routing of data.
5. **Fetch drops request:** fetch is denied 3 times (contested), then drops `if_req` for 1 cycle, then contests again. Required: `starve_cnt` clears to 0, and fetch is next granted only after 4 further data wins.
6. **Reset mid-read:** `rst` is pulsed in the cycle after a D read grant. Required:
   - `d_rvalid` is 0;
   - both grants and `mem_w_en` are 0 while `rst` is high;
   - normal arbitration resumes on the first cycle after `rst` is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
// Pure declarations: no logic, no latency, no flow control.
package mem_arb_pkg;
    localparam int ADDR_W_DEF     = 12;
    localparam int DATA_W_DEF     = 32;
    localparam int MAX_STARVE_DEF = 4;
    localparam int CNT_W          = 4;

    // Word-address memory map of the shared RAM.
    localparam int IM_BASE     = 0;
    localparam int DM_BASE     = 2048;
    localparam int DM_OUT_BASE = 3072;
    localparam int DONE_ADDR   = 4095;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } rd_owner_e;
endpackage

// File: rtl/arb_starve_prio.sv
// Data-priority two-way grant with a fetch starvation counter; grants are combinational (0 cycles).
// A losing requester is simply not granted and must hold its request.
module arb_starve_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_STARVE = MAX_STARVE_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);
    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             force_if;

    assign force_if = (starve_cnt_q == CNT_W'(MAX_STARVE));

    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if_gnt = if_req && (!d_req || force_if);
            d_gnt  = d_req && !if_gnt;
        end
        // Counts only data wins while fetch is waiting; any fetch grant or idle fetch clears it.
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port RAM between fetch and data ports; 0-cycle grant, read data 1 cycle after grant.
// Ungranted requesters hold their request; one access per cycle.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_STARVE = MAX_STARVE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    rd_owner_e         owner_q;
    rd_owner_e         owner_d;

    arb_starve_prio #(
        .MAX_STARVE(MAX_STARVE)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .if_req(if_req),
        .d_req (d_req),
        .if_gnt(if_gnt),
        .d_gnt (d_gnt)
    );

    // Idle cycles keep the last address on the RAM so its read port output stays put.
    always_comb begin
        addr_d  = addr_q;
        owner_d = OWN_NONE;
        if (d_gnt) begin
            addr_d = d_addr;
            if (!d_we) begin
                owner_d = OWN_D;
            end
        end else if (if_gnt) begin
            addr_d  = if_addr;
            owner_d = OWN_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            owner_q <= OWN_NONE;
        end else begin
            addr_q  <= addr_d;
            owner_q <= owner_d;
        end
    end

    assign mem_addr   = addr_d;
    assign mem_w_en   = d_gnt && d_we;
    assign mem_w_data = d_wdata;

    assign if_rvalid = (owner_q == OWN_IF);
    assign d_rvalid  = (owner_q == OWN_D);
    assign if_rdata  = mem_r_data;
    assign d_rdata   = mem_r_data;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: driver predicts grants/memory traffic from the arbitration rules, monitor checks read returns.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_w_data;
    logic [DW-1:0] mem_r_data = '0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_STARVE(MS)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_w_data(mem_w_data),
        .mem_r_data(mem_r_data)
    );

    // Behavioural single-port synchronous RAM.
    logic [DW-1:0] ram [0:4095];
    always @(posedge clk) begin
        if (mem_w_en) ram[mem_addr] <= mem_w_data;
        mem_r_data <= ram[mem_addr];
    end

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        bit            to_d;
        logic [DW-1:0] data;
    } rd_t;
    rd_t expq[$];

    logic [DW-1:0] model_mem [0:4095];
    int            data_wins = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every read return must match the oldest outstanding expectation due this cycle.
    always @(negedge clk) begin
        rd_t e;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            check("rvalid_if", 64'(if_rvalid), 64'(!e.to_d));
            check("rvalid_d", 64'(d_rvalid), 64'(e.to_d));
            check(e.to_d ? "d_rdata" : "if_rdata", 64'(e.to_d ? d_rdata : if_rdata), 64'(e.data));
        end else if (if_rvalid || d_rvalid) begin
            check("spurious_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
        end
    end

    task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        output bit ig, output bit dg);
        bit exp_if, exp_d;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        exp_if = ir && (!dr || data_wins == MS);
        exp_d  = dr && !exp_if;
        #1;
        ig = if_gnt;
        dg = d_gnt;
        check("if_gnt", 64'(if_gnt), 64'(exp_if));
        check("d_gnt", 64'(d_gnt), 64'(exp_d));
        check("mem_w_en", 64'(mem_w_en), 64'(exp_d && dw));
        check("starve_cnt", 64'(u_dut.u_arb.starve_cnt_q), 64'(data_wins));
        if (exp_d) last_addr = da;
        else if (exp_if) last_addr = ia;
        check("mem_addr", 64'(mem_addr), 64'(last_addr));
        if (exp_d && dw) begin
            check("mem_w_data", 64'(mem_w_data), 64'(dd));
            model_mem[da] = dd;
        end
        if (exp_d && !dw) expq.push_back('{due: cyc + 1, to_d: 1'b1, data: model_mem[da]});
        if (exp_if) expq.push_back('{due: cyc + 1, to_d: 1'b0, data: model_mem[ia]});
        if (!ir || exp_if) data_wins = 0;
        else data_wins++;
    endtask

    task automatic idle();
        bit ig, dg;
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, ig, dg);
    endtask

    // Raises reset for one cycle with both ports requesting a write-capable access.
    task automatic pulse_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if_req = 1'b1; if_addr = AW'(5); d_req = 1'b1; d_we = 1'b1; d_addr = AW'(12'hC00); d_wdata = 32'hDEAD_BEEF;
        expq.delete();
        data_wins = 0;
        last_addr = '0;
        #1;
        check("rst_if_gnt", 64'(if_gnt), 64'd0);
        check("rst_d_gnt", 64'(d_gnt), 64'd0);
        check("rst_mem_w_en", 64'(mem_w_en), 64'd0);
        check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        check("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ig, dg, pi, pd, dw;
        int nif, k;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dd;

        for (int i = 0; i < 4096; i++) begin
            ram[i] = DW'(i + 32'h100);
            model_mem[i] = DW'(i + 32'h100);
        end

        // Reset state, with both requests high to confirm grants are suppressed.
        #1;
        pulse_rst();

        // Fetch only, consecutive addresses.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, AW'(i), 1'b0, 1'b0, '0, '0, ig, dg);
            check("fetch_only_gnt", 64'(ig), 64'd1);
        end
        idle();
        idle();

        // Data write to the top word with fetch idle.
        step(1'b0, '0, 1'b1, 1'b1, AW'(12'hFFF), 32'hFFFF_FFFF, ig, dg);
        check("write_gnt", 64'(dg), 64'd1);
        idle();
        check("ram_4095", 64'(ram[4095]), 64'h0000_0000_FFFF_FFFF);

        // Both contending continuously: D,D,D,D,IF repeating.
        nif = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, AW'(16 + i), 1'b1, 1'b0, AW'(2048 + i), '0, ig, dg);
            check("contest_pattern", 64'(ig), 64'((i % 5) == 4));
            if (ig) nif++;
        end
        check("contest_if_count", 64'(nif), 64'd3);
        idle();

        // Interleaved reads by different requesters.
        step(1'b0, '0, 1'b1, 1'b0, AW'(12'h800), '0, ig, dg);
        step(1'b1, AW'(4), 1'b0, 1'b0, '0, '0, ig, dg);
        idle();
        idle();

        // Fetch drops its request after three losses; the starvation window restarts.
        for (int i = 0; i < 3; i++) step(1'b1, AW'(7), 1'b1, 1'b0, AW'(2100 + i), '0, ig, dg);
        step(1'b0, '0, 1'b1, 1'b0, AW'(2103), '0, ig, dg);
        k = 0;
        ig = 1'b0;
        while (!ig && k < 20) begin
            step(1'b1, AW'(7), 1'b1, 1'b0, AW'(2104 + k), '0, ig, dg);
            k++;
        end
        check("refetch_wait", 64'(k), 64'd5);
        idle();

        // Reset in the cycle after a data read grant.
        step(1'b0, '0, 1'b1, 1'b0, AW'(12'h801), '0, ig, dg);
        pulse_rst();
        step(1'b0, '0, 1'b1, 1'b0, AW'(12'h802), '0, ig, dg);
        check("post_rst_gnt", 64'(dg), 64'd1);
        idle();

        // Randomized traffic with request holding and occasional fetch drops.
        pi = 1'b0; pd = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pi && $urandom_range(0, 99) < 60) begin
                pi = 1'b1;
                ia = AW'($urandom_range(0, 2047));
            end else if (pi && $urandom_range(0, 99) < 5) begin
                pi = 1'b0;
            end
            if (!pd && $urandom_range(0, 99) < 70) begin
                pd = 1'b1;
                dw = 1'($urandom_range(0, 1));
                da = AW'($urandom_range(2048, 4095));
                dd = $urandom;
            end
            step(pi, ia, pd, dw, da, dd, ig, dg);
            if (ig) pi = 1'b0;
            if (dg) pd = 1'b0;
        end
        idle();
        idle();
        idle();
        check("queue_drained", 64'(expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
